// File: rtl/bnn_psum_binarizer.sv
// Accumulates GROUPS signed partial sums per neuron, thresholds each sum to one bit,
// and packs the bits into 27-bit words. Define BNN_ACC_SATURATE_EN for a saturating accumulator.
module bnn_psum_binarizer #(
  parameter int WIDTH     = 14,
  parameter int ACC_WIDTH = 18,
  parameter int GROUPS    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 psum_valid_in,
  input  logic [WIDTH-1:0]     psum_in,
  output logic                 psum_ready_out,
  input  logic [ACC_WIDTH-1:0] threshold_in,
  input  logic                 flush_in,
  output logic                 act_valid_out,
  input  logic                 act_ready_in,
  output logic [26:0]          activation_out,
  output logic [4:0]           act_count_out
);
  localparam int PACK_W = 27;
  localparam logic [7:0] GRP_LAST = 8'(GROUPS - 1);
  localparam logic [4:0] IDX_LAST = 5'(PACK_W - 1);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           grp_q, grp_d;
  logic [4:0]           idx_q, idx_d;
  logic [PACK_W-1:0]    pack_q, pack_d;
  logic                 act_valid_q, act_valid_d;
  logic [PACK_W-1:0]    act_word_q, act_word_d;
  logic [4:0]           act_count_q, act_count_d;

  logic                 beat, flush_ok, last_beat, bit_val, word_done;
  logic [ACC_WIDTH-1:0] psum_ext, sum;
  logic [PACK_W-1:0]    pack_upd;
  logic [4:0]           idx_upd;

  assign psum_ready_out = !act_valid_q || act_ready_in;
  assign beat           = psum_valid_in && psum_ready_out;
  assign flush_ok       = flush_in && psum_ready_out;
  assign psum_ext       = {{(ACC_WIDTH-WIDTH){psum_in[WIDTH-1]}}, psum_in};

`ifdef BNN_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] sum_wide;
  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {psum_ext[ACC_WIDTH-1], psum_ext};
  always_comb begin
    sum = sum_wide[ACC_WIDTH-1:0];
    // Sign bits disagree only on overflow; clamp toward the sign of the true result.
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end
`else
  assign sum = acc_q + psum_ext;
`endif

  assign last_beat = beat && (grp_q == GRP_LAST);
  assign bit_val   = $signed(sum) >= $signed(threshold_in);
  assign word_done = last_beat && (idx_q == IDX_LAST);
  assign idx_upd   = last_beat ? idx_q + 5'd1 : idx_q;

  genvar gi;
  generate
    for (gi = 0; gi < PACK_W; gi++) begin : g_pack
      assign pack_upd[gi] = (last_beat && idx_q == 5'(gi)) ? bit_val : pack_q[gi];
    end
  endgenerate

  always_comb begin
    acc_d       = acc_q;
    grp_d       = grp_q;
    pack_d      = pack_upd;
    idx_d       = idx_upd;
    act_valid_d = act_valid_q;
    act_word_d  = act_word_q;
    act_count_d = act_count_q;

    if (beat) begin
      if (last_beat) begin
        acc_d = '0;
        grp_d = '0;
      end else begin
        acc_d = sum;
        grp_d = grp_q + 8'd1;
      end
    end
    if (flush_ok) begin
      acc_d = '0;
      grp_d = '0;
    end

    if (act_valid_q && act_ready_in)
      act_valid_d = 1'b0;

    // A beat that completes the word takes precedence; a same-cycle flush then has nothing left.
    if (word_done) begin
      act_valid_d = 1'b1;
      act_word_d  = pack_upd;
      act_count_d = 5'(PACK_W);
      pack_d      = '0;
      idx_d       = '0;
    end else if (flush_ok && idx_upd != 5'd0) begin
      act_valid_d = 1'b1;
      act_word_d  = pack_upd;
      act_count_d = idx_upd;
      pack_d      = '0;
      idx_d       = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q       <= '0;
      grp_q       <= '0;
      idx_q       <= '0;
      pack_q      <= '0;
      act_valid_q <= 1'b0;
      act_word_q  <= '0;
      act_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      grp_q       <= grp_d;
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      act_valid_q <= act_valid_d;
      act_word_q  <= act_word_d;
      act_count_q <= act_count_d;
    end
  end

  assign act_valid_out  = act_valid_q;
  assign activation_out = act_word_q;
  assign act_count_out  = act_count_q;

endmodule

// File: tb/tb_bnn_psum_binarizer.sv
// Bench for bnn_psum_binarizer: three instances (GROUPS 4, 1, 255) share stimulus and are
// checked every cycle against a per-instance arithmetic model. Honours BNN_ACC_SATURATE_EN.
module tb_bnn_psum_binarizer;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, pv, fl, ar;
  logic signed [13:0]   ps;
  logic signed [AW-1:0] thr;

  logic        pr [3];
  logic        av [3];
  logic [26:0] aw [3];
  logic [4:0]  ac [3];

  int G [3] = '{4, 1, 255};

  bnn_psum_binarizer #(.WIDTH(14), .ACC_WIDTH(AW), .GROUPS(4)) u_dut_g4 (
    .clk_in(clk), .rst_in(rst), .psum_valid_in(pv), .psum_in(ps), .psum_ready_out(pr[0]),
    .threshold_in(thr), .flush_in(fl), .act_valid_out(av[0]), .act_ready_in(ar),
    .activation_out(aw[0]), .act_count_out(ac[0]));

  bnn_psum_binarizer #(.WIDTH(14), .ACC_WIDTH(AW), .GROUPS(1)) u_dut_g1 (
    .clk_in(clk), .rst_in(rst), .psum_valid_in(pv), .psum_in(ps), .psum_ready_out(pr[1]),
    .threshold_in(thr), .flush_in(fl), .act_valid_out(av[1]), .act_ready_in(ar),
    .activation_out(aw[1]), .act_count_out(ac[1]));

  bnn_psum_binarizer #(.WIDTH(14), .ACC_WIDTH(AW), .GROUPS(255)) u_dut_g255 (
    .clk_in(clk), .rst_in(rst), .psum_valid_in(pv), .psum_in(ps), .psum_ready_out(pr[2]),
    .threshold_in(thr), .flush_in(fl), .act_valid_out(av[2]), .act_ready_in(ar),
    .activation_out(aw[2]), .act_count_out(ac[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic longint acc_add(input longint a, input longint p);
    longint s;
    s = a + p;
`ifdef BNN_ACC_SATURATE_EN
    if (s > (longint'(1) << (AW-1)) - 1) s = (longint'(1) << (AW-1)) - 1;
    if (s < -(longint'(1) << (AW-1)))    s = -(longint'(1) << (AW-1));
`else
    s = s & ((longint'(1) << AW) - 1);
    if (s >= (longint'(1) << (AW-1))) s = s - (longint'(1) << AW);
`endif
    return s;
  endfunction

  longint      m_acc  [3];
  int          m_grp  [3];
  int          m_n    [3];
  logic [26:0] m_bits [3];
  bit          m_v    [3];
  logic [26:0] m_word [3];
  int          m_cnt  [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_grp[k] = 0; m_n[k] = 0; m_bits[k] = '0;
      m_v[k] = 1'b0; m_word[k] = '0; m_cnt[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        bit rdy, bt, fo;
        if (rst) begin
          m_acc[k] = 0; m_grp[k] = 0; m_n[k] = 0; m_bits[k] = '0;
          m_v[k] = 1'b0; m_word[k] = '0; m_cnt[k] = 0;
        end else begin
          rdy = !m_v[k] || ar;
          bt  = pv && rdy;
          fo  = fl && rdy;
          if (m_v[k] && ar) m_v[k] = 1'b0;
          if (bt) begin
            m_acc[k] = acc_add(m_acc[k], longint'(ps));
            m_grp[k]++;
            if (m_grp[k] == G[k]) begin
              m_bits[k][m_n[k]] = (m_acc[k] >= longint'(thr));
              m_n[k]++;
              m_acc[k] = 0;
              m_grp[k] = 0;
              if (m_n[k] == 27) begin
                m_v[k] = 1'b1; m_word[k] = m_bits[k]; m_cnt[k] = 27;
                m_bits[k] = '0; m_n[k] = 0;
              end
            end
          end
          if (fo) begin
            m_acc[k] = 0;
            m_grp[k] = 0;
            if (m_n[k] > 0) begin
              m_v[k] = 1'b1; m_word[k] = m_bits[k]; m_cnt[k] = m_n[k];
              m_bits[k] = '0; m_n[k] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("g%0d_valid", G[k]), 32'(av[k]), 32'(m_v[k]));
        chk($sformatf("g%0d_ready", G[k]), 32'(pr[k]), 32'(!m_v[k] || ar));
        if (m_v[k]) begin
          chk($sformatf("g%0d_word", G[k]), 32'(aw[k]), 32'(m_word[k]));
          chk($sformatf("g%0d_count", G[k]), 32'(ac[k]), 32'(m_cnt[k]));
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input int v);
    pv = 1'b1;
    ps = 14'(v);
    cycle();
    pv = 1'b0;
  endtask

  task automatic do_flush();
    fl = 1'b1;
    cycle();
    fl = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_g%0d_valid", tag, G[k]), 32'(av[k]), 32'd0);
      chk($sformatf("%s_g%0d_word", tag, G[k]), 32'(aw[k]), 32'd0);
      chk($sformatf("%s_g%0d_count", tag, G[k]), 32'(ac[k]), 32'd0);
      chk($sformatf("%s_g%0d_ready", tag, G[k]), 32'(pr[k]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; pv = 1'b0; ps = '0; fl = 1'b0; ar = 1'b1; thr = '0;
    cycle();
    cycle();
    rst = 1'b0;
    chk_zero("reset");

    // GROUPS=1 alternating +18/-18 against threshold 0
    thr = 0;
    for (int i = 0; i < 27; i++) begin
      if (i == 26) chk("alt_g1_not_early", 32'(av[1]), 32'd0);
      beat((i % 2 == 0) ? 18 : -18);
    end
    chk("alt_g1_valid", 32'(av[1]), 32'd1);
    chk("alt_g1_word", 32'(aw[1]), 32'h5555555);
    chk("alt_g1_count", 32'(ac[1]), 32'd27);
    cycle();

    // GROUPS=4 threshold 10: sums 10 and 9, then flush the two bits
    do_reset();
    thr = 10;
    beat(3); beat(3); beat(3); beat(1);
    beat(3); beat(3); beat(3); beat(0);
    do_flush();
    chk("flush2_g4_valid", 32'(av[0]), 32'd1);
    chk("flush2_g4_word", 32'(aw[0]), 32'h0000001);
    chk("flush2_g4_count", 32'(ac[0]), 32'd2);
    cycle();

    // Flush with no completed bit emits nothing and discards the partial neuron
    do_reset();
    thr = 10;
    beat(100); beat(100);
    do_flush();
    chk("flush0_g4_valid", 32'(av[0]), 32'd0);
    beat(-1); beat(-1); beat(-1); beat(-1);
    chk("fresh_g4_no_early", 32'(av[0]), 32'd0);
    do_flush();
    chk("fresh_g4_valid", 32'(av[0]), 32'd1);
    chk("fresh_g4_word", 32'(aw[0]), 32'h0000000);
    chk("fresh_g4_count", 32'(ac[0]), 32'd1);
    cycle();

    // Backpressure: hold a full word, offer more beats, then release
    do_reset();
    thr = 0;
    ar = 1'b0;
    for (int i = 0; i < 108; i++) beat(1);
    chk("stall_g4_valid", 32'(av[0]), 32'd1);
    chk("stall_g4_word", 32'(aw[0]), 32'h7FFFFFF);
    chk("stall_g4_count", 32'(ac[0]), 32'd27);
    for (int i = 0; i < 108; i++) beat(-5);
    chk("stall_g4_ready", 32'(pr[0]), 32'd0);
    chk("stall_g4_hold", 32'(aw[0]), 32'h7FFFFFF);
    ar = 1'b1;
    for (int j = 0; j < 27; j++)
      for (int b = 0; b < 4; b++) beat((j % 2 == 0) ? 1 : -1);
    chk("resume_g4_valid", 32'(av[0]), 32'd1);
    chk("resume_g4_word", 32'(aw[0]), 32'h5555555);
    cycle();

    // Large accumulation: saturate or wrap
    do_reset();
    thr = 0;
    for (int i = 0; i < 255; i++) beat(8191);
    chk("big_g255_no_word", 32'(av[2]), 32'd0);
    do_flush();
    chk("big_g255_valid", 32'(av[2]), 32'd1);
`ifdef BNN_ACC_SATURATE_EN
    chk("big_g255_word", 32'(aw[2]), 32'd1);
`else
    chk("big_g255_word", 32'(aw[2]), 32'd0);
`endif
    chk("big_g255_count", 32'(ac[2]), 32'd1);
    cycle();

    // Reset mid-word discards partial bits
    do_reset();
    thr = 0;
    for (int i = 0; i < 52; i++) beat(1);
    chk("mid_g4_pending", 32'(av[0]), 32'd0);
    do_reset();
    chk_zero("midrst");
    for (int i = 0; i < 108; i++) beat(1);
    chk("after_rst_g4_valid", 32'(av[0]), 32'd1);
    chk("after_rst_g4_word", 32'(aw[0]), 32'h7FFFFFF);
    chk("after_rst_g4_count", 32'(ac[0]), 32'd27);
    cycle();

    // Beat completing a word together with a flush yields a single word
    do_reset();
    thr = 0;
    for (int i = 0; i < 26; i++) beat(1);
    pv = 1'b1; ps = 14'(1); fl = 1'b1;
    cycle();
    pv = 1'b0; fl = 1'b0;
    chk("bf_g1_valid", 32'(av[1]), 32'd1);
    chk("bf_g1_word", 32'(aw[1]), 32'h7FFFFFF);
    chk("bf_g1_count", 32'(ac[1]), 32'd27);
    cycle();
    chk("bf_g1_no_extra", 32'(av[1]), 32'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
